// File: rtl/hpi_access_ctrl_if.sv
// ---------------------------------------------------------------------------
// hpi_access_ctrl_if
// Request/response channel between a requester (NIOS bridge, keycode poller)
// and hpi_access_ctrl.
//   req_valid  requester -> ctrl  request present, held until accepted
//   req_ready  ctrl -> requester  ctrl can accept this cycle
//   req_we     requester -> ctrl  1 = write, 0 = read
//   req_addr   requester -> ctrl  HPI register select
//   req_wdata  requester -> ctrl  write data
//   rsp_valid  ctrl -> requester  one-cycle completion pulse
//   rsp_rdata  ctrl -> requester  read data, held between reads
// ---------------------------------------------------------------------------
interface hpi_access_ctrl_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [1:0]  req_addr;
  logic [15:0] req_wdata;
  logic        rsp_valid;
  logic [15:0] rsp_rdata;

  modport master (
    output req_valid, req_we, req_addr, req_wdata,
    input  req_ready, rsp_valid, rsp_rdata
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata,
    output req_ready, rsp_valid, rsp_rdata
  );
endinterface

// File: rtl/hpi_access_ctrl.sv
// ---------------------------------------------------------------------------
// hpi_access_ctrl
// Runs one 16-bit read or write at a time on the CY7C67200 host-port
// interface: SETUP -> STROBE -> HOLD -> RECOVER, each phase lasting a
// programmable number of cycles, and drives the OTG chip reset.
//
// Optional feature macro: HPI_AUTORESET_EN. When defined, the block holds
// hpi_rst_n low for RST_CYC cycles after i_reset drops (state RST_HOLD)
// before accepting requests. When undefined, hpi_rst_n simply follows
// ~i_reset one cycle late.
//
// Ports
//   i_clk           system clock
//   i_reset         synchronous, active-high reset
//   bus             request/response channel (slave side)
//   o_hpi_addr      HPI register address
//   i_hpi_data_in   HPI data from the pad
//   o_hpi_data_out  HPI data to the pad
//   o_hpi_data_oe   pad output enable (never high during a read)
//   o_hpi_cs_n      chip select, active low
//   o_hpi_rd_n      read strobe, active low
//   o_hpi_wr_n      write strobe, active low
//   o_hpi_rst_n     OTG chip reset, active low
//   o_busy          high whenever the FSM is not in IDLE
// ---------------------------------------------------------------------------
module hpi_access_ctrl #(
  parameter int SETUP_CYC   = 1,
  parameter int STROBE_CYC  = 4,
  parameter int HOLD_CYC    = 1,
  parameter int RECOVER_CYC = 2,
  parameter int RST_CYC     = 16
) (
  input  logic               i_clk,
  input  logic               i_reset,
  hpi_access_ctrl_if.slave   bus,
  output logic [1:0]         o_hpi_addr,
  input  logic [15:0]        i_hpi_data_in,
  output logic [15:0]        o_hpi_data_out,
  output logic               o_hpi_data_oe,
  output logic               o_hpi_cs_n,
  output logic               o_hpi_rd_n,
  output logic               o_hpi_wr_n,
  output logic               o_hpi_rst_n,
  output logic               o_busy
);

  localparam int MAX_A = (SETUP_CYC > STROBE_CYC) ? SETUP_CYC : STROBE_CYC;
  localparam int MAX_B = (HOLD_CYC > RECOVER_CYC) ? HOLD_CYC : RECOVER_CYC;
  localparam int MAX_C = (MAX_A > MAX_B) ? MAX_A : MAX_B;
  localparam int MAXP  = (MAX_C > RST_CYC) ? MAX_C : RST_CYC;
  localparam int CW    = (MAXP > 1) ? $clog2(MAXP) : 1;

  // Each phase counts down from N-1 to 0, so N cycles per phase.
  localparam logic [CW-1:0] L_SETUP   = CW'(SETUP_CYC - 1);
  localparam logic [CW-1:0] L_STROBE  = CW'(STROBE_CYC - 1);
  localparam logic [CW-1:0] L_HOLD    = CW'(HOLD_CYC - 1);
  localparam logic [CW-1:0] L_RECOVER = CW'(RECOVER_CYC - 1);
`ifdef HPI_AUTORESET_EN
  localparam logic [CW-1:0] L_RST     = CW'(RST_CYC - 1);
`endif

  typedef enum logic [2:0] {
    S_IDLE, S_SETUP, S_STROBE, S_HOLD, S_RECOVER, S_RST_HOLD
  } state_t;

  state_t         r_state, w_state_nx;
  logic [CW-1:0]  r_cnt, w_cnt_nx;
  logic           w_last;
  logic [CW-1:0]  w_dec;
  logic           w_ready;
  logic           w_accept;

  logic           r_we;
  logic [1:0]     r_addr;
  logic [15:0]    r_wdata;

  logic           r_cs_n, r_rd_n, r_wr_n, r_oe, r_rsp, r_rst_n;
  logic [1:0]     r_hpi_addr;
  logic [15:0]    r_dout, r_rdata;
  logic           w_cs_n, w_rd_n, w_wr_n, w_oe, w_rsp;
  logic [1:0]     w_hpi_addr;
  logic [15:0]    w_dout, w_rdata;

  assign w_last   = (r_cnt == '0);
  assign w_dec    = r_cnt - CW'(1);
  assign w_ready  = (r_state == S_IDLE) & ~i_reset;
  assign w_accept = w_ready & bus.req_valid;

  // State register
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
`ifdef HPI_AUTORESET_EN
      r_state <= S_RST_HOLD;
      r_cnt   <= L_RST;
`else
      r_state <= S_IDLE;
      r_cnt   <= '0;
`endif
    end else begin
      r_state <= w_state_nx;
      r_cnt   <= w_cnt_nx;
    end
  end

  // Next-state logic; the counter is reloaded on every phase entry
  always_comb begin
    w_state_nx = r_state;
    w_cnt_nx   = r_cnt;
    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          w_state_nx = S_SETUP;
          w_cnt_nx   = L_SETUP;
        end
      end
      S_SETUP: begin
        if (w_last) begin
          w_state_nx = S_STROBE;
          w_cnt_nx   = L_STROBE;
        end else begin
          w_cnt_nx = w_dec;
        end
      end
      S_STROBE: begin
        if (w_last) begin
          w_state_nx = S_HOLD;
          w_cnt_nx   = L_HOLD;
        end else begin
          w_cnt_nx = w_dec;
        end
      end
      S_HOLD: begin
        if (w_last) begin
          w_state_nx = S_RECOVER;
          w_cnt_nx   = L_RECOVER;
        end else begin
          w_cnt_nx = w_dec;
        end
      end
      S_RECOVER: begin
        if (w_last) begin
          w_state_nx = S_IDLE;
          w_cnt_nx   = '0;
        end else begin
          w_cnt_nx = w_dec;
        end
      end
`ifdef HPI_AUTORESET_EN
      S_RST_HOLD: begin
        if (w_last) begin
          w_state_nx = S_IDLE;
          w_cnt_nx   = '0;
        end else begin
          w_cnt_nx = w_dec;
        end
      end
`endif
      default: begin
        w_state_nx = S_IDLE;
        w_cnt_nx   = '0;
      end
    endcase
  end

  // Request fields are captured only at acceptance and held for the access
  always_ff @(posedge i_clk) begin
    if (w_accept) begin
      r_we    <= bus.req_we;
      r_addr  <= bus.req_addr;
      r_wdata <= bus.req_wdata;
    end
  end

  // Output logic: pad values for the next cycle, derived from the current
  // phase, so every pad output lags the state by exactly one cycle.
  always_comb begin
    w_cs_n     = 1'b1;
    w_rd_n     = 1'b1;
    w_wr_n     = 1'b1;
    w_oe       = 1'b0;
    w_rsp      = 1'b0;
    w_hpi_addr = r_hpi_addr;
    w_dout     = r_dout;
    w_rdata    = r_rdata;
    case (r_state)
      S_SETUP: begin
        w_cs_n     = 1'b0;
        w_hpi_addr = r_addr;
        w_oe       = r_we;
        if (r_we) w_dout = r_wdata;
      end
      S_STROBE: begin
        w_cs_n = 1'b0;
        w_oe   = r_we;
        w_rd_n = r_we;
        w_wr_n = ~r_we;
        // Sample the pad while RD_n is still low, at the end of the strobe
        if (!r_we && w_last) w_rdata = i_hpi_data_in;
      end
      S_HOLD: begin
        w_cs_n = 1'b0;
        w_oe   = r_we;
      end
      S_RECOVER: begin
        w_rsp = (r_cnt == L_RECOVER);
      end
      default: ;
    endcase
  end

  // Output registers; reset aborts any access in flight
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_cs_n     <= 1'b1;
      r_rd_n     <= 1'b1;
      r_wr_n     <= 1'b1;
      r_oe       <= 1'b0;
      r_rsp      <= 1'b0;
      r_hpi_addr <= 2'd0;
      r_dout     <= 16'd0;
      r_rdata    <= 16'd0;
      r_rst_n    <= 1'b0;
    end else begin
      r_cs_n     <= w_cs_n;
      r_rd_n     <= w_rd_n;
      r_wr_n     <= w_wr_n;
      r_oe       <= w_oe;
      r_rsp      <= w_rsp;
      r_hpi_addr <= w_hpi_addr;
      r_dout     <= w_dout;
      r_rdata    <= w_rdata;
`ifdef HPI_AUTORESET_EN
      // Registered from the next state so the chip reset releases in the
      // same cycle that req_ready rises.
      r_rst_n    <= (w_state_nx != S_RST_HOLD);
`else
      r_rst_n    <= 1'b1;
`endif
    end
  end

  assign bus.req_ready  = w_ready;
  assign bus.rsp_valid  = r_rsp;
  assign bus.rsp_rdata  = r_rdata;
  assign o_hpi_addr     = r_hpi_addr;
  assign o_hpi_data_out = r_dout;
  assign o_hpi_data_oe  = r_oe;
  assign o_hpi_cs_n     = r_cs_n;
  assign o_hpi_rd_n     = r_rd_n;
  assign o_hpi_wr_n     = r_wr_n;
  assign o_hpi_rst_n    = r_rst_n;
  assign o_busy         = (r_state != S_IDLE);

endmodule

// File: doc/hpi_access_ctrl.md
Name: hpi_access_ctrl

Overview:
Sequences single 16-bit read/write transactions on the CY7C67200 OTG host-port interface (HPI) for the lab8 USB keyboard path. It takes one request at a time from a requester, for example the NIOS-side bridge or a keycode poller, through a valid/ready handshake. It generates the active-low CS/RD/WR strobes with programmable setup/strobe/hold/recovery timing and returns read data with a one-cycle response pulse. It also drives the OTG chip reset.

Parameters:
SETUP_CYC, 1, cycles the address and CS are stable before the strobe (≥1)
STROBE_CYC, 4, cycles RD_n/WR_n are held low (≥1)
HOLD_CYC, 1, cycles CS, address and write data stay valid after the strobe rises (≥1)
RECOVER_CYC, 2, cycles CS is high between transactions (≥1)
RST_CYC, 16, OTG reset pulse length in cycles (used only with HPI_AUTORESET_EN)

Ports:
Clk  in  1  system clock; one clock domain
Reset  in  1  synchronous, active-high reset
req_valid  in  1  request present; held stable until accepted
req_ready  out  1  block can accept; acceptance = req_valid & req_ready at a rising edge
req_we  in  1  1 = write, 0 = read
req_addr  in  2  HPI register select (0 DATA, 1 MAILBOX, 2 ADDRESS, 3 STATUS)
req_wdata  in  16  write data
rsp_valid  out  1  one-cycle pulse: transaction complete
rsp_rdata  out  16  read data; valid when rsp_valid is high and the transaction was a read; holds its value otherwise
hpi_addr  out  2  HPI address
hpi_data_in  in  16  HPI data from the pad
hpi_data_out  out  16  HPI data to the pad
hpi_data_oe  out  1  pad output enable
hpi_cs_n  out  1  chip select, active low
hpi_rd_n  out  1  read strobe, active low
hpi_wr_n  out  1  write strobe, active low
hpi_rst_n  out  1  OTG reset, active low
busy  out  1  high in any state other than IDLE

Behaviour:
- All outputs are registered except req_ready and busy.
- req_ready = (state==IDLE) & ~Reset.
- Reset values: state IDLE, hpi_cs_n=1, hpi_rd_n=1, hpi_wr_n=1, hpi_data_oe=0, hpi_addr=0, hpi_data_out=0, rsp_valid=0, rsp_rdata=0.
- States: IDLE, SETUP, STROBE, HOLD, RECOVER. One down-counter, sized with $clog2 of the largest parameter, is loaded on each state entry.
- IDLE:
  - On acceptance, latch we/addr/wdata and go to SETUP.
  - req_* fields are sampled only at acceptance.
- SETUP, SETUP_CYC cycles:
  - cs_n=0, hpi_addr=latched addr.
  - For writes: oe=1, data_out=wdata.
  - For reads: oe=0.
- STROBE, STROBE_CYC cycles:
  - rd_n=0 for a read, wr_n=0 for a write.
  - Reads: hpi_data_in is captured into rsp_rdata on the last STROBE cycle edge.
- HOLD, HOLD_CYC cycles:
  - Strobes are high; cs_n, addr, oe and data_out are unchanged.
- RECOVER, RECOVER_CYC cycles:
  - cs_n=1, oe=0.
  - rsp_valid=1 on the first RECOVER cycle only.
  - Exits to IDLE.
- Latency, with acceptance at edge T:
  - rsp_valid is high in cycle T+SETUP+STROBE+HOLD+1 (defaults: T+7).
  - The earliest next acceptance is at edge T+SETUP+STROBE+HOLD+RECOVER+1 (defaults: T+9).
- rd_n and wr_n are never low simultaneously. oe is never high during a read.
- Reset asserted mid-transaction:
  - Abort at that edge; all strobes/CS deassert and oe=0.
  - No rsp_valid for the aborted transaction.
- req_valid high while busy: ignored, no queueing.
- Without the feature: hpi_rst_n is a register = ~Reset, so it is low during the reset cycle(s) and 1 after.

Optional Feature:
HPI_AUTORESET_EN
- Defined:
  - Adds state RST_HOLD, entered from Reset.
  - hpi_rst_n=0 for RST_CYC cycles after Reset deasserts, then 1; the state then goes to IDLE.
  - req_ready=0 and busy=1 throughout RST_HOLD.
  - Reset during RST_HOLD restarts the count.
- Undefined:
  - No RST_HOLD state; IDLE immediately after Reset.
  - hpi_rst_n behaves as described under Behaviour.

Test Plan:
1. Write, default parameters: accept at T with we=1, addr=2, wdata=0x1234 ->
   - cs_n low T+1..T+6; wr_n low T+2..T+5; rd_n stays 1.
   - oe=1 and data_out=0x1234 T+1..T+6.
   - rsp_valid only at T+7; req_ready returns at T+9.
2. Read: accept addr=0 with hpi_data_in=0xBEEF during STROBE ->
   - rd_n low T+2..T+5, oe=0 throughout.
   - rsp_valid at T+7 with rsp_rdata=0xBEEF.
3. Back-to-back: req_valid held high for two requests ->
   - Second accepted exactly at T+9.
   - No request is lost or duplicated; exactly two rsp_valid pulses.
4. Reset asserted at T+3 during STROBE -> next cycle:
   - cs_n=1, rd_n=1, wr_n=1, oe=0.
   - No rsp_valid ever; a new request is accepted the cycle after Reset drops.
5. Non-default timing: SETUP=2, STROBE=1, HOLD=3, RECOVER=1 -> strobe width exactly 1 cycle; rsp_valid at T+7; next accept at T+8.
6. With HPI_AUTORESET_EN and RST_CYC=16: release Reset ->
   - hpi_rst_n=0 for 16 cycles with req_ready=0.
   - Then hpi_rst_n=1 and req_ready=1; a request issued during the hold is accepted only afterwards.
